// File: rtl/accum_run_if.sv
// accum_run_if
//   Control/status bundle between the test/control logic and accum_run_ctrl.
//   master : drives start, pause, clear and limit; observes the status outputs.
//   slave  : the controller side.
//   Ports carried:
//     start      1  pulse: load limit, clear acc, enter RUN
//     pause      1  level: freeze the run
//     clear      1  pulse: abort to IDLE
//     limit      W  stop value, sampled on an accepted start
//     acc_val    W  current accumulator value
//     busy       1  high in RUN or PAUSE
//     stop_flag  1  sticky "limit reached"
//     done_pulse 1  one-cycle strobe on RUN->DONE
interface accum_run_if #(
  parameter int W = 16
);
  logic         start;
  logic         pause;
  logic         clear;
  logic [W-1:0] limit;
  logic [W-1:0] acc_val;
  logic         busy;
  logic         stop_flag;
  logic         done_pulse;

  modport master (
    output start, pause, clear, limit,
    input  acc_val, busy, stop_flag, done_pulse
  );

  modport slave (
    input  start, pause, clear, limit,
    output acc_val, busy, stop_flag, done_pulse
  );
endinterface

// File: rtl/accum_run_ctrl.sv
// accum_run_ctrl
//   Run/stop controller for a stepped accumulator. While running, the
//   accumulator advances by STEP once every TICK_DIV clocks and saturates at
//   the programmed limit, at which point the run halts, stop_flag is set and
//   done_pulse strobes for one clock.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    accum_run_if.slave (start/pause/clear/limit in; acc_val/busy/
//            stop_flag/done_pulse out, all registered)
//   Configuration macro: AUTO_RESTART_EN
//     defined   -> DONE lasts one clock, then the run restarts with the same limit
//     undefined -> DONE is terminal until start or clear (default)
module accum_run_ctrl #(
  parameter int W        = 16,
  parameter int STEP     = 10,
  parameter int TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  accum_run_if.slave  bus
);

  localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [W:0]       STEP_X   = (W + 1)'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     limit_q, limit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             busy_q, busy_d;
  logic             flag_q, flag_d;
  logic             done_q, done_d;
  logic [W:0]       sum_s;

  // Next-state computation: clear > start > pause, then the tick/saturate logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    limit_d = limit_q;
    div_d   = div_q;
    flag_d  = flag_q;
    done_d  = 1'b0;
    // One bit wider than acc so an overshoot past 2**W-1 is still seen as >= limit.
    sum_s   = {1'b0, acc_q} + STEP_X;

    if (bus.clear) begin
      state_d = S_IDLE;
      acc_d   = '0;
      div_d   = '0;
      flag_d  = 1'b0;
    end else if (bus.start) begin
      state_d = S_RUN;
      acc_d   = '0;
      div_d   = '0;
      limit_d = bus.limit;
      flag_d  = 1'b0;
    end else begin
      case (state_q)
        S_RUN, S_PAUSE: begin
          if (bus.pause) begin
            // Pause also wins over a terminal tick: nothing advances this cycle.
            state_d = S_PAUSE;
          end else begin
            // Releasing pause counts on the same edge, so a pause of N clocks
            // delays completion by exactly N clocks.
            state_d = S_RUN;
            if (div_q == DIV_LAST) begin
              div_d = '0;
              if (sum_s >= {1'b0, limit_q}) begin
                acc_d   = limit_q;
                state_d = S_DONE;
                flag_d  = 1'b1;
                done_d  = 1'b1;
              end else begin
                acc_d = sum_s[W-1:0];
              end
            end else begin
              div_d = div_q + DIV_ONE;
            end
          end
        end
        S_DONE: begin
`ifdef AUTO_RESTART_EN
          // stop_flag deliberately stays set across the automatic restart.
          state_d = S_RUN;
          acc_d   = '0;
          div_d   = '0;
`else
          state_d = S_DONE;
`endif
        end
        S_IDLE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          acc_d   = '0;
          div_d   = '0;
          flag_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      limit_q <= '0;
      div_q   <= '0;
      busy_q  <= 1'b0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      limit_q <= limit_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  assign bus.acc_val    = acc_q;
  assign bus.busy       = busy_q;
  assign bus.stop_flag  = flag_q;
  assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_accum_run_ctrl.sv
// tb_accum_run_ctrl
//   Directed bench for accum_run_ctrl (default build, AUTO_RESTART_EN undefined).
//   A behavioural model predicts every cycle; predictions are queued when the
//   stimulus is driven and popped/compared after the clock edge. Directed
//   latency/value checks are layered on top. A second instance (W=8, STEP=200)
//   covers the no-wrap saturation corner.
module tb_accum_run_ctrl;

  logic clk;
  logic rst_n;

  accum_run_if #(.W(16)) bus ();
  accum_run_if #(.W(8))  bus8 ();

  accum_run_ctrl #(.W(16), .STEP(10), .TICK_DIV(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  accum_run_ctrl #(.W(8), .STEP(200), .TICK_DIV(10)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] acc;
    logic        busy;
    logic        flag;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Behavioural model state: 0=IDLE 1=RUN 2=PAUSE 3=DONE
  int   m_st, m_acc, m_div, m_lim;
  bit   m_flag, m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_acc = 0; m_div = 0; m_lim = 0; m_flag = 0; m_done = 0;
  endtask

  // One clock: drive inputs, queue the model prediction, compare after the edge.
  task automatic cyc(input logic s, input logic p, input logic c, input logic [15:0] lim);
    exp_t e;
    bit   running;
    bus.start = s; bus.pause = p; bus.clear = c; bus.limit = lim;
    running = (m_st == 1) || (m_st == 2);
    m_done  = 0;
    if (c) begin
      m_st = 0; m_acc = 0; m_div = 0; m_flag = 0;
    end else if (s) begin
      m_st = 1; m_acc = 0; m_div = 0; m_lim = int'(lim); m_flag = 0;
    end else if (running && p) begin
      m_st = 2;
    end else if (running) begin
      m_st  = 1;
      m_div = m_div + 1;
      if (m_div == 10) begin
        m_div = 0;
        if (m_acc + 10 >= m_lim) begin
          m_acc = m_lim; m_st = 3; m_flag = 1; m_done = 1;
        end else begin
          m_acc = m_acc + 10;
        end
      end
    end
    e.acc  = m_acc;
    e.busy = (m_st == 1) || (m_st == 2);
    e.flag = m_flag;
    e.done = m_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("acc_val",    {16'd0, bus.acc_val}, e.acc);
    chk("busy",       {31'd0, bus.busy},       {31'd0, e.busy});
    chk("stop_flag",  {31'd0, bus.stop_flag},  {31'd0, e.flag});
    chk("done_pulse", {31'd0, bus.done_pulse}, {31'd0, e.done});
    bus.start = 1'b0;
    bus.clear = 1'b0;
  endtask

  // Idle-input cycles until done_pulse, then check the number of clocks taken.
  task automatic run_done(input string tag, input int exp_n);
    int n;
    n = 0;
    while (!bus.done_pulse && n < 400) begin
      cyc(1'b0, 1'b0, 1'b0, 16'd0);
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0; bus.limit = 16'd0;
    bus8.start = 1'b0; bus8.pause = 1'b0; bus8.clear = 1'b0; bus8.limit = 8'd0;
    model_reset();

    // Reset values
    #12;
    chk("rst_acc",  {16'd0, bus.acc_val}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_flag", {31'd0, bus.stop_flag}, 32'd0);
    chk("rst_done", {31'd0, bus.done_pulse}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic run to 100
    cyc(1'b1, 1'b0, 1'b0, 16'd100);
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("s1_first_step", {16'd0, bus.acc_val}, 32'd10);
    run_done("s1_latency", 90);
    chk("s1_acc_final", {16'd0, bus.acc_val}, 32'd100);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("s1_busy_done", {31'd0, bus.busy}, 32'd0);
    chk("s1_flag_held", {31'd0, bus.stop_flag}, 32'd1);
    repeat (12) cyc(1'b0, 1'b0, 1'b0, 16'd0);

    // 2: limit not a multiple of STEP saturates to 95
    cyc(1'b1, 1'b0, 1'b0, 16'd95);
    run_done("s2_latency", 100);
    chk("s2_acc_sat", {16'd0, bus.acc_val}, 32'd95);

    // 3: 37-clock pause once acc reaches 30
    cyc(1'b1, 1'b0, 1'b0, 16'd100);
    repeat (30) cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("s3_acc30", {16'd0, bus.acc_val}, 32'd30);
    repeat (37) cyc(1'b0, 1'b1, 1'b0, 16'd0);
    chk("s3_frozen", {16'd0, bus.acc_val}, 32'd30);
    chk("s3_busy_paused", {31'd0, bus.busy}, 32'd1);
    run_done("s3_latency_after_pause", 70);

    // 4: clear mid-run, start+clear together, restart mid-run with a smaller limit
    cyc(1'b1, 1'b0, 1'b0, 16'd100);
    repeat (50) cyc(1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 1'b1, 16'd0);
    chk("s4_clear_acc", {16'd0, bus.acc_val}, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 16'd100);
    chk("s4_start_clear_idle", {31'd0, bus.busy}, 32'd0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'd100);
    repeat (70) cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("s4_acc70", {16'd0, bus.acc_val}, 32'd70);
    cyc(1'b1, 1'b0, 1'b0, 16'd20);
    chk("s4_restart_acc", {16'd0, bus.acc_val}, 32'd0);
    run_done("s4_restart_latency", 20);
    chk("s4_acc20", {16'd0, bus.acc_val}, 32'd20);

    // 5a: limit=0 finishes on the first tick with acc=0
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    run_done("s5_limit0_latency", 10);
    chk("s5_limit0_acc", {16'd0, bus.acc_val}, 32'd0);

    // 5b: pause in the same cycle as a terminal tick wins
    cyc(1'b1, 1'b0, 1'b0, 16'd10);
    repeat (9) cyc(1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b1, 1'b0, 16'd0);
    chk("s5_pause_wins_done", {31'd0, bus.done_pulse}, 32'd0);
    run_done("s5_after_pause", 1);

    // 5c: async reset mid-run clears outputs immediately
    cyc(1'b1, 1'b0, 1'b0, 16'd100);
    repeat (25) cyc(1'b0, 1'b0, 1'b0, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_arst_acc",  {16'd0, bus.acc_val}, 32'd0);
    chk("s5_arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("s5_arst_flag", {31'd0, bus.stop_flag}, 32'd0);
    chk("s5_arst_done", {31'd0, bus.done_pulse}, 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'd0);

    // 5d: W=8, STEP=200, limit=255 -> 200 then 255, no wrap
    bus8.limit = 8'd255;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("s5_w8_first", {24'd0, bus8.acc_val}, 32'd200);
    repeat (10) @(posedge clk);
    #1;
    chk("s5_w8_sat",  {24'd0, bus8.acc_val}, 32'd255);
    chk("s5_w8_done", {31'd0, bus8.done_pulse}, 32'd1);
    chk("s5_w8_flag", {31'd0, bus8.stop_flag}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("s5_w8_hold", {24'd0, bus8.acc_val}, 32'd255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
